demultiplexer1to4_buffered: RTL and testbench
=============================================

// Module: demultiplexer1to4_buffered
// PURPOSE
//  Counterpart of the 4:1 selector mux: routes one upstream stream to one of four
//  downstream sinks chosen by a 2-bit selector. Sits between the store/write-back
//  path and up to four memory-mapped consumers (data memory, GPIO, UART, timer).
//  Each output channel has a 1-entry holding register with valid/ready handshake,
//  and a per-channel transfer counter for debug/perf.
// PARAMETERS
//  NBits    32  data width of input and each output channel
//  CntBits  8   width of each per-channel accepted-transfer counter (wraps)
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          asynchronous, active-low reset
//  Selector       in   2          destination channel for current input beat
//  DEMUX_Valid    in   1          upstream beat valid
//  DEMUX_Data     in   NBits      upstream data
//  DEMUX_Ready    out  1          upstream may transfer this cycle
//  OUT_Valid      out  4          bit i: channel i holds valid data
//  OUT_Ready      in   4          bit i: sink i accepts channel i this cycle
//  OUT_Data0..3   out  NBits each channel i holding-register contents
//  OUT_Count      out  4*CntBits  channel i count at [i*CntBits +: CntBits]
// BEHAVIOUR
//  Reset (reset=0, async): OUT_Valid=0, OUT_Data0..3=0, OUT_Count=0; DEMUX_Ready=0
//   while reset asserted; in-flight beats in holding regs are discarded.
//  Per channel i, state {EMPTY, FULL} (== OUT_Valid[i]):
//   - accept_i  = DEMUX_Valid & DEMUX_Ready & (Selector==i)
//   - drain_i   = OUT_Valid[i] & OUT_Ready[i]
//   - EMPTY: accept_i -> FULL, OUT_Data_i <= DEMUX_Data
//   - FULL: drain_i & !accept_i -> EMPTY; drain_i & accept_i -> stay FULL, load new
//     data (back-to-back, full throughput); !drain_i -> hold data stable
//  DEMUX_Ready (combinational) = reset & (!OUT_Valid[Selector] | OUT_Ready[Selector]).
//   Depends only on the selected channel; a stalled channel never blocks others
//   once Selector changes.
//  Latency: input accepted in cycle N appears on OUT_Data_i/OUT_Valid[i] in N+1.
//  Only the selected channel updates on accept; unselected channels drain freely
//   in the same cycle (simultaneous accept on ch j and drain on ch k allowed).
//  OUT_Data_i and OUT_Valid[i] must not change while FULL and OUT_Ready[i]=0.
//  OUT_Data_i retains last value when EMPTY (not cleared on drain).
//  OUT_Count_i increments by 1 on each accept_i, modulo 2^CntBits (255 -> 0 at
//   default); counts accepts, not drains.
//  Selector/DEMUX_Data ignored when DEMUX_Valid=0; no combinational path from
//   DEMUX_Valid to DEMUX_Ready.
// TESTING
//  1 Reset: drive reset=0 mid-stream with ch2 FULL -> OUT_Valid=4'b0000, all
//    counts 0, DEMUX_Ready=0 immediately (no clock edge needed).
//  2 Routing: Valid=1, Selector=0..3, Data=32'hA0..A3, all OUT_Ready=1 -> each
//    OUT_Valid[i] pulses one cycle later with OUT_Data_i=32'hA0+i; counts =1 each.
//  3 Backpressure: OUT_Ready[1]=0, send 32'h11 then 32'h22 to ch1 -> 32'h11 held,
//    DEMUX_Ready=0 on second beat; raise OUT_Ready[1] -> 32'h22 loads same edge.
//  4 Isolation: ch1 stalled FULL, switch Selector=3 -> DEMUX_Ready=1, ch3 gets
//    32'h33 next cycle while ch1 still holds 32'h11.
//  5 Throughput: ch0 ready=1, 10 consecutive beats -> DEMUX_Ready stays 1,
//    OUT_Valid[0] high 10 consecutive cycles, count0=10.
//  6 Wrap: 256 accepts to ch2 (CntBits=8) -> count2 returns to 0; others unchanged.

Source files
------------

// File: rtl/demultiplexer1to4_buffered.sv
// 1:4 demultiplexer with a one-entry holding register per output channel.
// Each channel has a valid/ready handshake and a wrapping count of accepted beats.
module demultiplexer1to4_buffered #(
  parameter int NBits   = 32,
  parameter int CntBits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Selector,
  input  logic                 DEMUX_Valid,
  input  logic [NBits-1:0]     DEMUX_Data,
  output logic                 DEMUX_Ready,
  output logic [3:0]           OUT_Valid,
  input  logic [3:0]           OUT_Ready,
  output logic [NBits-1:0]     OUT_Data0,
  output logic [NBits-1:0]     OUT_Data1,
  output logic [NBits-1:0]     OUT_Data2,
  output logic [NBits-1:0]     OUT_Data3,
  output logic [4*CntBits-1:0] OUT_Count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t        state  [4];
  logic [NBits-1:0]   data_q [4];
  logic [CntBits-1:0] cnt_q  [4];
  logic [3:0]         accept;
  logic [3:0]         drain;

  // Ready looks only at the selected channel, so DEMUX_Valid never feeds it.
  always_comb begin
    DEMUX_Ready = reset & (~OUT_Valid[Selector] | OUT_Ready[Selector]);
    accept      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      accept[i] = DEMUX_Valid & DEMUX_Ready & (Selector == 2'(i));
    end
    drain = OUT_Valid & OUT_Ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i]  <= EMPTY;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        // Accept wins over drain: a simultaneous drain+accept keeps the slot full.
        if (accept[i]) begin
          state[i]  <= FULL;
          data_q[i] <= DEMUX_Data;
          cnt_q[i]  <= cnt_q[i] + 1'b1;
        end else if (drain[i]) begin
          state[i]  <= EMPTY;
        end
      end
    end
  end

  always_comb begin
    OUT_Valid = '0;
    OUT_Count = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      OUT_Valid[i]                 = (state[i] == FULL);
      OUT_Count[i*CntBits +: CntBits] = cnt_q[i];
    end
    OUT_Data0 = data_q[0];
    OUT_Data1 = data_q[1];
    OUT_Data2 = data_q[2];
    OUT_Data3 = data_q[3];
  end

endmodule

// File: tb/tb_demultiplexer1to4_buffered.sv
// Bench for demultiplexer1to4_buffered: directed scenarios plus random traffic,
// checked by a queue-per-channel scoreboard sampled on the falling edge.
module tb_demultiplexer1to4_buffered;

  localparam int NB = 32;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sel = '0;
  logic          dv = 1'b0;
  logic [NB-1:0] dd = '0;
  logic          drdy;
  logic [3:0]    ov;
  logic [3:0]    ordy = '0;
  logic [NB-1:0] od0, od1, od2, od3;
  logic [4*CB-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference: a channel holds data iff its queue is non-empty; counts are plain integers.
  logic [NB-1:0] q [4][$];
  int unsigned   m_cnt [4];

  demultiplexer1to4_buffered #(.NBits(NB), .CntBits(CB)) dut (
    .clk(clk), .reset(reset), .Selector(sel), .DEMUX_Valid(dv), .DEMUX_Data(dd),
    .DEMUX_Ready(drdy), .OUT_Valid(ov), .OUT_Ready(ordy),
    .OUT_Data0(od0), .OUT_Data1(od1), .OUT_Data2(od2), .OUT_Data3(od3),
    .OUT_Count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] od_of(input int i);
    case (i)
      0:       return od0;
      1:       return od1;
      2:       return od2;
      default: return od3;
    endcase
  endfunction

  // Monitor/scoreboard: inputs change at posedge+1, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        m_cnt[i] = 0;
      end
    end else begin
      logic exp_rdy;
      exp_rdy = (q[sel].size() == 0) || ordy[sel];
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid%0d", i), 64'(ov[i]), 64'(q[i].size() != 0));
        if (q[i].size() != 0) begin
          chk($sformatf("data%0d", i), 64'(od_of(i)), 64'(q[i][0]));
          if (ordy[i]) void'(q[i].pop_front());
        end
        chk($sformatf("count%0d", i), 64'(cnt[i*CB +: CB]), 64'(m_cnt[i] % 256));
      end
      chk("demux_ready", 64'(drdy), 64'(exp_rdy));
      if (dv && exp_rdy) begin
        q[sel].push_back(dd);
        m_cnt[sel]++;
      end
    end
  end

  task automatic cyc(input logic v, input logic [1:0] s, input logic [NB-1:0] d,
                     input logic [3:0] r);
    dv = v; sel = s; dd = d; ordy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(ov), 64'h0);
    chk("rst_count", 64'(cnt), 64'h0);
    chk("rst_ready", 64'(drdy), 64'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Routing to each channel
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), NB'(32'hA0 + i), 4'hF);
    cyc(1'b0, 2'd0, '0, 4'hF);
    chk("route_counts", 64'(cnt), 64'h01010101);
    chk("route_drained", 64'(ov), 64'h0);

    // Backpressure on ch1, then isolation via ch3
    cyc(1'b1, 2'd1, 32'h11, 4'b1101);
    dv = 1'b1; sel = 2'd1; dd = 32'h22; ordy = 4'b1101;
    #1 chk("bp_ready_low", 64'(drdy), 64'h0);
    @(posedge clk); #1;
    chk("bp_hold", 64'(od1), 64'h11);
    dv = 1'b1; sel = 2'd3; dd = 32'h33; ordy = 4'b1101;
    #1 chk("iso_ready", 64'(drdy), 64'h1);
    @(posedge clk); #1;
    chk("iso_ch3", 64'(od3), 64'h33);
    chk("iso_ch1", 64'(od1), 64'h11);
    cyc(1'b1, 2'd1, 32'h22, 4'b1111);
    chk("bp_reload", 64'(od1), 64'h22);
    chk("bp_valid", 64'(ov[1]), 64'h1);
    cyc(1'b0, 2'd0, '0, 4'hF);

    // Throughput: 10 back-to-back beats on ch0
    for (int i = 0; i < 10; i++) begin
      dv = 1'b1; sel = 2'd0; dd = NB'(32'hB00 + i); ordy = 4'hF;
      #1 chk("tp_ready", 64'(drdy), 64'h1);
      @(posedge clk); #1;
      chk("tp_valid", 64'(ov[0]), 64'h1);
    end
    cyc(1'b0, 2'd0, '0, 4'hF);
    chk("tp_count0", 64'(cnt[0 +: CB]), 64'd11);

    // Mid-stream reset with ch2 full
    cyc(1'b1, 2'd2, 32'hC2, 4'b1011);
    dv = 1'b0; sel = 2'd0; ordy = 4'b1011;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov), 64'h0);
    chk("mid_rst_count", 64'(cnt), 64'h0);
    chk("mid_rst_ready", 64'(drdy), 64'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Counter wrap on ch2 with ch1 holding a count of 1
    cyc(1'b1, 2'd1, 32'h5151, 4'hF);
    for (int i = 0; i < 256; i++) cyc(1'b1, 2'd2, $urandom, 4'hF);
    cyc(1'b0, 2'd0, '0, 4'hF);
    chk("wrap_count2", 64'(cnt[2*CB +: CB]), 64'h0);
    chk("wrap_others", 64'(cnt), 64'h00000100);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
          4'($urandom_range(0, 15) | $urandom_range(0, 15)));
    end
    repeat (3) cyc(1'b0, 2'd0, '0, 4'hF);
    chk("final_empty", 64'(ov), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
